// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control unit: sequences FETCH/DECODE/EXEC/MEM/WB and registers decoded datapath controls.
// Optional build macro MCU_ILLEGAL_TRAP_EN: unknown opcodes halt with a fault instead of executing as a NOP.
module multicycle_control_unit #(
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned WAIT_W   = 4
) (
    input  logic        MCUClk,
    input  logic        MCURst,
    input  logic [31:0] MCUInst,
    input  logic        MCUMemReady,
    output logic        MCUMemReq,
    output logic        MCUMemSel,
    output logic        MCUIRWr,
    output logic        MCUPCWr,
    output logic        MCURUWr,
    output logic        MCUDMWr,
    output logic [2:0]  MCUImmSrc,
    output logic        MCUALUASrc,
    output logic        MCUALUBSrc,
    output logic [4:0]  MCUBrOp,
    output logic [3:0]  MCUALUOp,
    output logic [2:0]  MCUDMCtrl,
    output logic [1:0]  MCURUDataWrSrc,
    output logic [2:0]  MCUState,
    output logic        MCUFault
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd7;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [4:0] BR_SEQ  = 5'b10101;

    // Instruction class selects the path taken after EXEC
    localparam logic [2:0] CL_WB    = 3'd0;
    localparam logic [2:0] CL_LOAD  = 3'd1;
    localparam logic [2:0] CL_STORE = 3'd2;
    localparam logic [2:0] CL_EXEC  = 3'd3;
    localparam logic [2:0] CL_TRAP  = 3'd4;

    logic [2:0]        state;
    logic [2:0]        state_next;
    logic [6:0]        ir_op;
    logic [4:0]        ir_rd;
    logic [2:0]        ir_f3;
    logic [6:0]        ir_f7;
    logic [2:0]        cls;
    logic              rd_nz;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_expired;
    logic              unused_inst_bits;

    logic [3:0] d_alu_op;
    logic [4:0] d_br_op;
    logic [2:0] d_imm_src;
    logic       d_a_src;
    logic       d_b_src;
    logic [2:0] d_dm_ctrl;
    logic [1:0] d_wr_src;
    logic [2:0] d_cls;
    logic       d_bad;

    assign unused_inst_bits = ^MCUInst[24:15];
    assign wait_expired     = (wait_cnt == WAIT_W'(WAIT_MAX - 1));
    assign MCUState         = state;

    // Instruction fields the control unit needs, captured on IR load
    always_ff @(posedge MCUClk) begin
        if (MCURst) begin
            ir_op <= 7'd0;
            ir_rd <= 5'd0;
            ir_f3 <= 3'd0;
            ir_f7 <= 7'd0;
        end else if (MCUIRWr) begin
            ir_op <= MCUInst[6:0];
            ir_rd <= MCUInst[11:7];
            ir_f3 <= MCUInst[14:12];
            ir_f7 <= MCUInst[31:25];
        end
    end

    always_comb begin
        d_alu_op  = 4'b0000;
        d_br_op   = BR_SEQ;
        d_imm_src = 3'b000;
        d_a_src   = 1'b0;
        d_b_src   = 1'b0;
        d_dm_ctrl = 3'b000;
        d_wr_src  = 2'b00;
        d_cls     = CL_EXEC;
        d_bad     = 1'b0;
        case (ir_op)
            OP_R: begin
                d_cls = CL_WB;
                if (ir_f7 == F7_BASE) begin
                    d_alu_op = {ir_f3 == 3'b101, ir_f3};
                end else if (ir_f7 == F7_ALT && ir_f3 == 3'b000) begin
                    d_alu_op = 4'b1000;
                end else if (ir_f7 == F7_ALT && ir_f3 == 3'b101) begin
                    d_alu_op = 4'b0101;
                end else begin
                    d_bad = 1'b1;
                end
            end
            OP_I: begin
                d_cls   = CL_WB;
                d_b_src = 1'b1;
                if (ir_f3 == 3'b001) begin
                    if (ir_f7 == F7_BASE) d_alu_op = 4'b0001;
                    else                  d_bad    = 1'b1;
                end else if (ir_f3 == 3'b101) begin
                    if (ir_f7 == F7_BASE)     d_alu_op = 4'b1101;
                    else if (ir_f7 == F7_ALT) d_alu_op = 4'b0101;
                    else                      d_bad    = 1'b1;
                end else begin
                    d_alu_op = {1'b0, ir_f3};
                end
            end
            OP_LOAD: begin
                d_cls     = CL_LOAD;
                d_b_src   = 1'b1;
                d_wr_src  = 2'b01;
                d_dm_ctrl = ir_f3;
                d_bad     = (ir_f3 == 3'b011) || (ir_f3 == 3'b110) || (ir_f3 == 3'b111);
            end
            OP_STORE: begin
                d_cls     = CL_STORE;
                d_imm_src = 3'b010;
                d_b_src   = 1'b1;
                d_dm_ctrl = ir_f3;
                d_bad     = (ir_f3 > 3'b010);
            end
            OP_BRANCH: begin
                d_cls     = CL_EXEC;
                d_imm_src = 3'b010;
                d_a_src   = 1'b1;
                d_b_src   = 1'b1;
                if (ir_f3 == 3'b010 || ir_f3 == 3'b011) d_bad   = 1'b1;
                else                                    d_br_op = {2'b00, ir_f3};
            end
            OP_LUI: begin
                d_cls     = CL_WB;
                d_imm_src = 3'b011;
                d_b_src   = 1'b1;
            end
            OP_AUIPC: begin
                d_cls     = CL_WB;
                d_imm_src = 3'b011;
                d_a_src   = 1'b1;
                d_b_src   = 1'b1;
            end
            OP_JAL: begin
                d_cls     = CL_WB;
                d_imm_src = 3'b100;
                d_a_src   = 1'b1;
                d_b_src   = 1'b1;
                d_br_op   = 5'b01111;
                d_wr_src  = 2'b10;
            end
            OP_JALR: begin
                d_cls    = CL_WB;
                d_b_src  = 1'b1;
                d_br_op  = 5'b10111;
                d_wr_src = 2'b10;
                d_bad    = (ir_f3 != 3'b000);
            end
            default: begin
`ifdef MCU_ILLEGAL_TRAP_EN
                d_cls = CL_TRAP;
`else
                d_cls = CL_EXEC;
`endif
            end
        endcase
        if (d_bad) begin
            d_alu_op  = 4'b0000;
            d_dm_ctrl = 3'b010;
        end
    end

    // Decoded controls are captured once per instruction and held until the next DECODE
    always_ff @(posedge MCUClk) begin
        if (MCURst) begin
            MCUALUOp       <= 4'b0000;
            MCUBrOp        <= BR_SEQ;
            MCUImmSrc      <= 3'b000;
            MCUALUASrc     <= 1'b0;
            MCUALUBSrc     <= 1'b0;
            MCUDMCtrl      <= 3'b000;
            MCURUDataWrSrc <= 2'b00;
            cls            <= CL_WB;
            rd_nz          <= 1'b0;
        end else if (state == S_DECODE) begin
            MCUALUOp       <= d_alu_op;
            MCUBrOp        <= d_br_op;
            MCUImmSrc      <= d_imm_src;
            MCUALUASrc     <= d_a_src;
            MCUALUBSrc     <= d_b_src;
            MCUDMCtrl      <= d_dm_ctrl;
            MCURUDataWrSrc <= d_wr_src;
            cls            <= d_cls;
            rd_nz          <= (ir_rd != 5'd0);
        end
    end

    always_ff @(posedge MCUClk) begin
        if (MCURst) state <= S_FETCH;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        MCUMemReq  = 1'b0;
        MCUMemSel  = 1'b0;
        MCUIRWr    = 1'b0;
        MCUPCWr    = 1'b0;
        MCURUWr    = 1'b0;
        MCUDMWr    = 1'b0;
        case (state)
            S_FETCH: begin
                MCUMemReq = 1'b1;
                if (MCUMemReady) begin
                    MCUIRWr    = 1'b1;
                    state_next = S_DECODE;
                end else if (wait_expired) begin
                    state_next = S_HALT;
                end
            end
            S_DECODE: state_next = (d_cls == CL_TRAP) ? S_HALT : S_EXEC;
            S_EXEC: begin
                if (cls == CL_EXEC) begin
                    MCUPCWr    = 1'b1;
                    state_next = S_FETCH;
                end else if (cls == CL_LOAD || cls == CL_STORE) begin
                    state_next = S_MEM;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM: begin
                MCUMemReq = 1'b1;
                MCUMemSel = 1'b1;
                MCUDMWr   = (cls == CL_STORE);
                if (MCUMemReady) begin
                    MCUPCWr    = (cls == CL_STORE);
                    state_next = (cls == CL_STORE) ? S_FETCH : S_WB;
                end else if (wait_expired) begin
                    state_next = S_HALT;
                end
            end
            S_WB: begin
                MCUPCWr    = 1'b1;
                MCURUWr    = rd_nz;
                state_next = S_FETCH;
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_FETCH;
        endcase
        // A reset cycle aborts whatever state was in flight without side effects
        if (MCURst) begin
            MCUMemReq = 1'b0;
            MCUMemSel = 1'b0;
            MCUIRWr   = 1'b0;
            MCUPCWr   = 1'b0;
            MCURUWr   = 1'b0;
            MCUDMWr   = 1'b0;
        end
    end

    // Counts unanswered request cycles; clears on ready or any state change
    always_ff @(posedge MCUClk) begin
        if (MCURst) begin
            wait_cnt <= '0;
        end else if (MCUMemReq && !MCUMemReady && state_next == state) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    always_ff @(posedge MCUClk) begin
        if (MCURst)                    MCUFault <= 1'b0;
        else if (state_next == S_HALT) MCUFault <= 1'b1;
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: per-cycle strobe scoreboard plus decoded-control checks.
module tb_multicycle_control_unit;

    localparam int unsigned WAIT_MAX = 15;
    localparam int K_WB = 0, K_LOAD = 1, K_STORE = 2, K_EXEC = 3, K_TRAP = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ready = 1'b0;
    logic [31:0] inst = 32'd0;

    logic       MCUMemReq, MCUMemSel, MCUIRWr, MCUPCWr, MCURUWr, MCUDMWr;
    logic [2:0] MCUImmSrc;
    logic       MCUALUASrc, MCUALUBSrc;
    logic [4:0] MCUBrOp;
    logic [3:0] MCUALUOp;
    logic [2:0] MCUDMCtrl;
    logic [1:0] MCURUDataWrSrc;
    logic [2:0] MCUState;
    logic       MCUFault;

    int checks = 0;
    int failures = 0;

    multicycle_control_unit #(.WAIT_MAX(WAIT_MAX), .WAIT_W(4)) dut (
        .MCUClk(clk), .MCURst(rst), .MCUInst(inst), .MCUMemReady(ready),
        .MCUMemReq(MCUMemReq), .MCUMemSel(MCUMemSel), .MCUIRWr(MCUIRWr),
        .MCUPCWr(MCUPCWr), .MCURUWr(MCURUWr), .MCUDMWr(MCUDMWr),
        .MCUImmSrc(MCUImmSrc), .MCUALUASrc(MCUALUASrc), .MCUALUBSrc(MCUALUBSrc),
        .MCUBrOp(MCUBrOp), .MCUALUOp(MCUALUOp), .MCUDMCtrl(MCUDMCtrl),
        .MCURUDataWrSrc(MCURUDataWrSrc), .MCUState(MCUState), .MCUFault(MCUFault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] inst;
        logic        rdy;
        logic [2:0]  st;
        logic        req, sel, irwr, pcwr, ruwr, dmwr, fault;
    } cyc_t;

    cyc_t q[$];

    function automatic void push_cyc(input logic [31:0] i, input logic r, input logic [2:0] s,
                                     input logic req, input logic sel, input logic irwr,
                                     input logic pcwr, input logic ruwr, input logic dmwr,
                                     input logic fault);
        cyc_t c;
        c = '{inst: i, rdy: r, st: s, req: req, sel: sel, irwr: irwr,
              pcwr: pcwr, ruwr: ruwr, dmwr: dmwr, fault: fault};
        q.push_back(c);
    endfunction

    function automatic void push_halt(input logic [31:0] i);
        repeat (3) push_cyc(i, 1'($urandom), 3'd7, 0, 0, 0, 0, 0, 0, 1);
    endfunction

    // Expected per-cycle behaviour of one instruction; fd/md are ready delays (>= WAIT_MAX means never ready)
    function automatic void push_instr(input logic [31:0] i, input int kind, input int fd, input int md);
        logic rd_nz, st;
        rd_nz = (i[11:7] != 5'd0);
        st    = (kind == K_STORE);
        if (fd >= int'(WAIT_MAX)) begin
            repeat (WAIT_MAX) push_cyc(i, 0, 3'd0, 1, 0, 0, 0, 0, 0, 0);
            push_halt(i);
            return;
        end
        repeat (fd) push_cyc(i, 0, 3'd0, 1, 0, 0, 0, 0, 0, 0);
        push_cyc(i, 1, 3'd0, 1, 0, 1, 0, 0, 0, 0);
        push_cyc(i, 1'($urandom), 3'd1, 0, 0, 0, 0, 0, 0, 0);
        if (kind == K_TRAP) begin
            push_halt(i);
            return;
        end
        push_cyc(i, 1'($urandom), 3'd2, 0, 0, 0, kind == K_EXEC, 0, 0, 0);
        if (kind == K_LOAD || kind == K_STORE) begin
            if (md >= int'(WAIT_MAX)) begin
                repeat (WAIT_MAX) push_cyc(i, 0, 3'd3, 1, 1, 0, 0, 0, st, 0);
                push_halt(i);
                return;
            end
            repeat (md) push_cyc(i, 0, 3'd3, 1, 1, 0, 0, 0, st, 0);
            push_cyc(i, 1, 3'd3, 1, 1, 0, st, 0, st, 0);
        end
        if (kind == K_WB || kind == K_LOAD)
            push_cyc(i, 1'($urandom), 3'd4, 0, 0, 0, 1, rd_nz, 0, 0);
    endfunction

    // Called at a negedge; drives each queued cycle and compares the DUT strobes in that cycle
    task automatic drain_scoreboard(input string name);
        cyc_t e, o;
        int n;
        n = 0;
        while (q.size() > 0) begin
            e = q.pop_front();
            inst  = e.inst;
            ready = e.rdy;
            #1;
            o = '{inst: e.inst, rdy: e.rdy, st: MCUState, req: MCUMemReq, sel: MCUMemSel,
                  irwr: MCUIRWr, pcwr: MCUPCWr, ruwr: MCURUWr, dmwr: MCUDMWr, fault: MCUFault};
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL %s cycle %0d inst=%h {st,req,sel,irwr,pcwr,ruwr,dmwr,fault} observed=%b required=%b",
                         name, n, e.inst, o[9:0], e[9:0]);
            end
            n++;
            @(negedge clk);
        end
    endtask

    task automatic apply_reset();
        rst   = 1'b1;
        ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        ready = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (MCUState !== 3'd0 || {MCUMemReq, MCUMemSel, MCUIRWr, MCUPCWr, MCURUWr, MCUDMWr} !== 6'b0 ||
            MCUFault !== 1'b0 || MCUBrOp !== 5'b10101 || MCUALUOp !== 4'b0 || MCUImmSrc !== 3'b0 ||
            MCUDMCtrl !== 3'b0 || MCURUDataWrSrc !== 2'b0 || MCUALUASrc !== 1'b0 || MCUALUBSrc !== 1'b0) begin
            failures++;
            $display("FAIL reset_values observed st=%0d strobes=%b fault=%b br=%b alu=%b imm=%b dm=%b src=%b required st=0 strobes=0 fault=0 br=10101 rest=0",
                     MCUState, {MCUMemReq, MCUMemSel, MCUIRWr, MCUPCWr, MCURUWr, MCUDMWr}, MCUFault,
                     MCUBrOp, MCUALUOp, MCUImmSrc, MCUDMCtrl, MCURUDataWrSrc);
        end
        @(negedge clk);
        rst   = 1'b0;
        ready = 1'b0;
    endtask

    task automatic test_alu();
        logic [31:0] ti [9] = '{32'h002081B3, 32'h402081B3, 32'h0020B2B3, 32'h40225213, 32'h00225213,
                                32'h00000013, 32'h0020F333, 32'h002091B3, 32'h202081B3};
        logic [3:0]  ta [9] = '{4'b0000, 4'b1000, 4'b0011, 4'b0101, 4'b1101,
                                4'b0000, 4'b0111, 4'b0001, 4'b0000};
        logic        tb [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 9; k++) begin
            push_instr(ti[k], K_WB, k % 3, 0);
            drain_scoreboard("alu_trace");
            checks++;
            if (MCUALUOp !== ta[k] || MCUALUBSrc !== tb[k] || MCUBrOp !== 5'b10101 ||
                MCURUDataWrSrc !== 2'b00 || (k == 8 && MCUDMCtrl !== 3'b010)) begin
                failures++;
                $display("FAIL alu_ctrl inst=%h observed alu=%b bsrc=%b br=%b src=%b dm=%b required alu=%b bsrc=%b br=10101 src=00",
                         ti[k], MCUALUOp, MCUALUBSrc, MCUBrOp, MCURUDataWrSrc, MCUDMCtrl, ta[k], tb[k]);
            end
        end
    endtask

    task automatic test_load_store();
        logic [31:0] ti [5] = '{32'h0080A283, 32'h0020A223, 32'h0000C283, 32'h00209123, 32'h0000A003};
        int          tk [5] = '{K_LOAD, K_STORE, K_LOAD, K_STORE, K_LOAD};
        int          tm [5] = '{3, 0, 1, 2, 0};
        logic [2:0]  td [5] = '{3'b010, 3'b010, 3'b100, 3'b001, 3'b010};
        logic [2:0]  tim [5] = '{3'b000, 3'b010, 3'b000, 3'b010, 3'b000};
        for (int k = 0; k < 5; k++) begin
            push_instr(ti[k], tk[k], k % 2, tm[k]);
            drain_scoreboard("mem_trace");
            checks++;
            if (MCUDMCtrl !== td[k] || MCUImmSrc !== tim[k] || MCUALUBSrc !== 1'b1 || MCUALUOp !== 4'b0000 ||
                (tk[k] == K_LOAD && MCURUDataWrSrc !== 2'b01)) begin
                failures++;
                $display("FAIL mem_ctrl inst=%h observed dm=%b imm=%b bsrc=%b alu=%b src=%b required dm=%b imm=%b bsrc=1 alu=0000",
                         ti[k], MCUDMCtrl, MCUImmSrc, MCUALUBSrc, MCUALUOp, MCURUDataWrSrc, td[k], tim[k]);
            end
        end
    endtask

    task automatic test_branch_jump();
        logic [31:0] ti [8] = '{32'h00209463, 32'h00208463, 32'h0020F463, 32'h0020C463,
                                32'h008000EF, 32'h000100E7, 32'h123453B7, 32'h12345397};
        int          tk [8] = '{K_EXEC, K_EXEC, K_EXEC, K_EXEC, K_WB, K_WB, K_WB, K_WB};
        logic [4:0]  tbr [8] = '{5'b00001, 5'b00000, 5'b00111, 5'b00100,
                                 5'b01111, 5'b10111, 5'b10101, 5'b10101};
        logic [2:0]  tim [8] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b100, 3'b000, 3'b011, 3'b011};
        logic [1:0]  tsr [8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00};
        for (int k = 0; k < 8; k++) begin
            push_instr(ti[k], tk[k], 0, 0);
            drain_scoreboard("br_trace");
            checks++;
            if (MCUBrOp !== tbr[k] || MCUImmSrc !== tim[k] ||
                (tk[k] == K_WB && MCURUDataWrSrc !== tsr[k]) || (k == 7 && MCUALUASrc !== 1'b1)) begin
                failures++;
                $display("FAIL br_ctrl inst=%h observed br=%b imm=%b src=%b asrc=%b required br=%b imm=%b src=%b",
                         ti[k], MCUBrOp, MCUImmSrc, MCURUDataWrSrc, MCUALUASrc, tbr[k], tim[k], tsr[k]);
            end
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        push_instr(32'h002081B3, K_WB, WAIT_MAX, 0);
        drain_scoreboard("fetch_timeout");
        repeat (4) @(negedge clk);
        checks++;
        if (MCUState !== 3'd7 || MCUFault !== 1'b1 || MCUMemReq !== 1'b0) begin
            failures++;
            $display("FAIL halt_sticky observed st=%0d fault=%b req=%b required st=7 fault=1 req=0",
                     MCUState, MCUFault, MCUMemReq);
        end
        apply_reset();
        checks++;
        if (MCUState !== 3'd0 || MCUFault !== 1'b0) begin
            failures++;
            $display("FAIL fault_clear observed st=%0d fault=%b required st=0 fault=0", MCUState, MCUFault);
        end
        push_instr(32'h002081B3, K_WB, WAIT_MAX - 1, 0);
        push_instr(32'h0080A283, K_LOAD, 0, WAIT_MAX - 1);
        drain_scoreboard("ready_at_expiry");
        push_instr(32'h0020A223, K_STORE, 0, WAIT_MAX);
        drain_scoreboard("mem_timeout");
        apply_reset();
    endtask

    task automatic test_illegal();
        apply_reset();
`ifdef MCU_ILLEGAL_TRAP_EN
        push_instr(32'h0000007F, K_TRAP, 0, 0);
        drain_scoreboard("illegal_trap");
        checks++;
        if (MCUState !== 3'd7 || MCUFault !== 1'b1) begin
            failures++;
            $display("FAIL illegal_halt observed st=%0d fault=%b required st=7 fault=1", MCUState, MCUFault);
        end
        apply_reset();
`else
        push_instr(32'h0000007F, K_EXEC, 0, 0);
        drain_scoreboard("illegal_nop");
        checks++;
        if (MCUState !== 3'd0 || MCUBrOp !== 5'b10101 || MCUFault !== 1'b0) begin
            failures++;
            $display("FAIL illegal_nop observed st=%0d br=%b fault=%b required st=0 br=10101 fault=0",
                     MCUState, MCUBrOp, MCUFault);
        end
`endif
    endtask

    task automatic test_reset_mid();
        inst  = 32'h002081B3;
        ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({MCUMemReq, MCUIRWr, MCUPCWr, MCURUWr, MCUDMWr} !== 5'b0) begin
            failures++;
            $display("FAIL reset_mid_strobes observed {req,irwr,pcwr,ruwr,dmwr}=%b required 00000",
                     {MCUMemReq, MCUIRWr, MCUPCWr, MCURUWr, MCUDMWr});
        end
        @(negedge clk);
        rst   = 1'b0;
        ready = 1'b0;
        checks++;
        if (MCUState !== 3'd0) begin
            failures++;
            $display("FAIL reset_mid_state observed st=%0d required st=0", MCUState);
        end
        push_instr(32'h0080A283, K_LOAD, 1, 0);
        drain_scoreboard("after_reset");
    endtask

    task automatic test_back_to_back();
        push_instr(32'h002081B3, K_WB, 0, 0);
        push_instr(32'h0080A283, K_LOAD, 0, 0);
        push_instr(32'h0020A223, K_STORE, 0, 0);
        push_instr(32'h00209463, K_EXEC, 0, 0);
        push_instr(32'h008000EF, K_WB, 2, 0);
        push_instr(32'h40225213, K_WB, 0, 0);
        drain_scoreboard("back_to_back");
        checks++;
        if (MCUALUOp !== 4'b0101 || MCUState !== 3'd0) begin
            failures++;
            $display("FAIL b2b_final observed alu=%b st=%0d required alu=0101 st=0", MCUALUOp, MCUState);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_alu();
        test_load_store();
        test_branch_jump();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        test_illegal();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multicycle RV32I control unit: FSM sequences each instruction through fetch, decode, execute, memory and writeback.
- Issues per-state write strobes and memory requests with a ready handshake.
- Decoded datapath controls are registered once per instruction.
- Sits between the unified instruction/data memory port and the existing datapath (register unit, immediate generator, ALU, branch unit, data memory).

Parameters:
WAIT_MAX, 15, max cycles MemReq may stay high without MemReady before fault
WAIT_W, 4, width of wait counter; must satisfy 2**WAIT_W > WAIT_MAX

Ports:
MCUClk  in  1  clock, rising edge
MCURst  in  1  reset, synchronous, active-high
MCUInst  in  32  instruction word from memory; sampled only when IRWr=1
MCUMemReady  in  1  memory completes current request this cycle
MCUMemReq  out  1  memory request strobe
MCUMemSel  out  1  0=instruction fetch, 1=data access
MCUIRWr  out  1  instruction register load strobe
MCUPCWr  out  1  PC update strobe, one pulse per instruction
MCURUWr  out  1  register-file write strobe
MCUDMWr  out  1  data memory write (valid with MemReq, MemSel=1)
MCUImmSrc  out  3  immediate format
MCUALUASrc  out  1  0=rs1, 1=PC
MCUALUBSrc  out  1  0=rs2, 1=imm
MCUBrOp  out  5  branch/next-PC op
MCUALUOp  out  4  ALU op
MCUDMCtrl  out  3  load/store size and sign
MCURUDataWrSrc  out  2  00=ALU, 01=memory, 10=PC+4
MCUState  out  3  current state encoding
MCUFault  out  1  sticky memory-timeout fault

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Ports are MCUClk and MCURst.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.
- Reset values: state FETCH, all strobes 0, MCUFault 0, registered controls 0, BrOp=10101, wait counter 0.
- Reset mid-operation aborts the instruction; no strobe is issued in the cycle after reset.
- FETCH: MemReq=1, MemSel=0.
  - On MemReady: IRWr=1 same cycle, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: one cycle. Controls are decoded from the latched IR and registered; they hold until the next DECODE.
- ALUOp: add 0000, sub 1000, sll 0001, slt 0010, sltu 0011, xor 0100, srl 1101, sra 0101, or 0110, and 0111.
  - funct7=0100000 selects sub/sra.
  - I-type funct3=101 also uses funct7: srli=1101, srai=0101.
- BrOp:
  - beq 00000, bne 00001, blt 00100, bge 00101, bltu 00110, bgeu 00111.
  - jal 01111, jalr 10111.
  - All others 10101 (sequential).
- ImmSrc: I=000, S/B=010, U=011, J=100.
- DMCtrl = funct3 for loads and stores.
- Transitions and strobes after EXEC:
  - R, I-ALU, lui, auipc: EXEC -> WB. RUWr=1 and PCWr=1 in WB, DataWrSrc=00.
  - Load: EXEC -> MEM (MemReq=1, MemSel=1, DMWr=0) -> on ready WB. RUWr=1, PCWr=1, DataWrSrc=01.
  - Store: EXEC -> MEM (DMWr=1). On ready PCWr=1, go to FETCH. RUWr never asserted.
  - Branch: PCWr=1 in EXEC, go to FETCH. Branch unit resolves taken/not-taken from BrOp.
  - jal, jalr: EXEC -> WB. RUWr=1, PCWr=1, DataWrSrc=10.
- rd=0: RUWr suppressed; all other behaviour unchanged.
- Latency in cycles with zero-wait memory: branch 3; ALU/U/jal/jalr/store 4; load 5.
- Wait counter:
  - Counts cycles with MemReq=1 and MemReady=0; clears on ready or on leaving the state.
  - When the count reaches WAIT_MAX with no ready, go to HALT and set MCUFault=1.
  - Ready in the expiry cycle wins: normal completion, no fault.
- HALT: all strobes 0, MemReq 0. Exit only by reset.
- Unknown funct3/funct7 within a known opcode decodes as ALUOp=0000 and DMCtrl=010. Other fields follow the opcode.

Optional Feature:
MCU_ILLEGAL_TRAP_EN
- Defined: an unknown opcode in DECODE goes to HALT with MCUFault=1. No PCWr, RUWr or DMWr.
- Undefined: an unknown opcode is a NOP: DECODE -> EXEC, PCWr=1 in EXEC, BrOp=10101, no other writes, then FETCH.

Test Plan:
- add x3,x1,x2 (0x002081B3), zero-wait memory -> states 0,1,2,4. ALUOp=0000, RUWr=1 and PCWr=1 only in WB. 4 cycles.
- lw x5,8(x1) (0x0080A283), data ready delayed 3 cycles -> MEM held 4 cycles, DMCtrl=010, DataWrSrc=01, RUWr in WB. Total 8 cycles.
- bne x1,x2,off (0x00209463) -> BrOp=00001, ImmSrc=010, PCWr in EXEC, no RUWr. 3 cycles.
- srai x4,x4,2 (0x40225213) vs srli (0x00225213) -> ALUOp 0101 vs 1101.
- Fetch with MemReady held low -> fault after WAIT_MAX=15 cycles, state 7, MCUFault=1 until MCURst. Ready on cycle 15 -> no fault.
- Opcode 0x0000007F -> with macro: HALT + fault. Without: PCWr pulse in EXEC, no RUWr, next FETCH.
